// File: rtl/dma_desc_fetch_mc.sv
// Multi-channel descriptor fetch engine: channels share one AVMM burst-read master,
// granted round-robin per descriptor; owned descriptors are pushed to per-channel FIFOs.
module dma_desc_fetch_mc #(
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int DESC_WORDS   = 8,
  parameter int NEXT_PTR_IDX = 4,
  parameter int OWN_BIT      = 31,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH*32-1:0]           csr_control_i,
  input  logic [NUM_CH*ADDR_W-1:0]       csr_first_pointer_i,
  output logic                           dma_desc_fetch_read_o,
  output logic [3:0]                     dma_desc_fetch_bcount_o,
  output logic [ADDR_W-1:0]              dma_desc_fetch_addr_o,
  input  logic                           dma_desc_fetch_waitrequest_i,
  input  logic [DATA_W-1:0]              dma_desc_fetch_rddata_i,
  input  logic                           dma_desc_fetch_readdatavalid_i,
  output logic [NUM_CH-1:0]              dma_desc_fifo_wr_o,
  output logic [DESC_WORDS*DATA_W-1:0]   dma_desc_fifo_wrdata_o,
  input  logic [NUM_CH-1:0]              dma_desc_fifo_full_i,
  output logic [NUM_CH-1:0]              dma_desc_fetch_busy_o,
  output logic [CH_W-1:0]                dma_desc_fetch_chan_o
);

  localparam int CNT_W = $clog2(DESC_WORDS + 1);
  localparam int DW    = DESC_WORDS * DATA_W;

  typedef enum logic [2:0] {IDLE, SEND_READ, WAIT_DATA, CHECK, FIFO_WAIT} state_t;

  state_t              state_q, state_d;
  logic                read_q, read_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_CH-1:0]   fifo_wr_q, fifo_wr_d;
  logic [DW-1:0]       words_q, words_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ptr_q [NUM_CH];
  logic [ADDR_W-1:0]   ptr_d [NUM_CH];
  logic [NUM_CH-1:0]   ptr_valid_q, ptr_valid_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [NUM_CH-1:0]   busy_q, busy_d;

  logic [NUM_CH-1:0]   run, park, elig;
  logic [CH_W-1:0]     grant, cand;
  logic                grant_found;
  logic                owned;
  logic [ADDR_W-1:0]   next_ptr;
  logic                unused_ctl;

  assign unused_ctl = ^csr_control_i;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      run[c]  = csr_control_i[32*c + 5];
      park[c] = csr_control_i[32*c + 17];
    end
    elig = run & ~done_q & ~dma_desc_fifo_full_i;
  end

  // Round-robin search begins just after the last granted channel and wraps.
  always_comb begin
    grant       = '0;
    cand        = '0;
    grant_found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(last_q) + i) % NUM_CH);
      if (!grant_found && elig[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  assign owned    = words_q[(DESC_WORDS-1)*DATA_W + OWN_BIT];
  assign next_ptr = words_q[NEXT_PTR_IDX*DATA_W +: ADDR_W];

  always_comb begin
    state_d     = state_q;
    read_d      = read_q;
    addr_d      = addr_q;
    fifo_wr_d   = '0;
    words_d     = words_q;
    chan_d      = chan_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    ptr_valid_d = ptr_valid_q;
    done_d      = done_q;

    for (int c = 0; c < NUM_CH; c++) begin
      if (!run[c]) begin
        ptr_valid_d[c] = 1'b0;
        done_d[c]      = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          chan_d = grant;
          last_d = grant;
          if (!ptr_valid_q[grant]) begin
            ptr_d[grant]       = csr_first_pointer_i[grant*ADDR_W +: ADDR_W];
            ptr_valid_d[grant] = 1'b1;
            addr_d             = csr_first_pointer_i[grant*ADDR_W +: ADDR_W];
          end else begin
            addr_d = ptr_q[grant];
          end
          read_d  = 1'b1;
          state_d = SEND_READ;
        end
      end
      SEND_READ: begin
        cnt_d = '0;
        if (dma_desc_fetch_readdatavalid_i) begin
          words_d[0 +: DATA_W] = dma_desc_fetch_rddata_i;
          cnt_d                = CNT_W'(1);
        end
        if (!dma_desc_fetch_waitrequest_i) begin
          read_d  = 1'b0;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (dma_desc_fetch_readdatavalid_i && (cnt_q < CNT_W'(DESC_WORDS))) begin
          words_d[int'(cnt_q)*DATA_W +: DATA_W] = dma_desc_fetch_rddata_i;
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_W'(DESC_WORDS)) state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        if (!run[chan_q]) begin
          state_d = IDLE;
        end else if (owned && !dma_desc_fifo_full_i[chan_q]) begin
          fifo_wr_d[chan_q] = 1'b1;
          ptr_d[chan_q]     = next_ptr;
        end else if (owned) begin
          state_d = FIFO_WAIT;
        end else if (park[chan_q]) begin
          ptr_valid_d[chan_q] = 1'b0;
        end else begin
          done_d[chan_q] = 1'b1;
        end
      end
      FIFO_WAIT: begin
        if (!run[chan_q]) begin
          state_d = IDLE;
        end else if (!dma_desc_fifo_full_i[chan_q]) begin
          fifo_wr_d[chan_q] = 1'b1;
          ptr_d[chan_q]     = next_ptr;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = run & ~done_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      read_q      <= 1'b0;
      addr_q      <= '0;
      fifo_wr_q   <= '0;
      words_q     <= '0;
      chan_q      <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
      cnt_q       <= '0;
      for (int c = 0; c < NUM_CH; c++) ptr_q[c] <= '0;
      ptr_valid_q <= '0;
      done_q      <= '0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
      fifo_wr_q   <= fifo_wr_d;
      words_q     <= words_d;
      chan_q      <= chan_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      ptr_valid_q <= ptr_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign dma_desc_fetch_read_o   = read_q;
  assign dma_desc_fetch_bcount_o = 4'(DESC_WORDS);
  assign dma_desc_fetch_addr_o   = addr_q;
  assign dma_desc_fifo_wr_o      = fifo_wr_q;
  assign dma_desc_fifo_wrdata_o  = words_q;
  assign dma_desc_fetch_busy_o   = busy_q;
  assign dma_desc_fetch_chan_o   = chan_q;

endmodule

// File: tb/tb_dma_desc_fetch_mc.sv
// Directed bench for dma_desc_fetch_mc: AVMM memory responder, FIFO-write monitor
// and hand-computed expectations for chain walking, arbitration, backpressure, park and reset.
module tb_dma_desc_fetch_mc;
  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DW     = 8 * DATA_W;

  logic                clk = 1'b0;
  logic                reset;
  logic [NUM_CH*32-1:0]     ctrl;
  logic [NUM_CH*ADDR_W-1:0] fptr;
  logic                read_o;
  logic [3:0]          bcount;
  logic [ADDR_W-1:0]   addr_o;
  logic                waitreq;
  logic [DATA_W-1:0]   rddata;
  logic                rdv;
  logic [NUM_CH-1:0]   fifo_wr;
  logic [DW-1:0]       wrdata;
  logic [NUM_CH-1:0]   full;
  logic [NUM_CH-1:0]   busy;
  logic                chan;

  always #5 clk = ~clk;

  dma_desc_fetch_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                      .DESC_WORDS(8), .NEXT_PTR_IDX(4), .OWN_BIT(31)) dut (
    .clk                           (clk),
    .reset                         (reset),
    .csr_control_i                 (ctrl),
    .csr_first_pointer_i           (fptr),
    .dma_desc_fetch_read_o         (read_o),
    .dma_desc_fetch_bcount_o       (bcount),
    .dma_desc_fetch_addr_o         (addr_o),
    .dma_desc_fetch_waitrequest_i  (waitreq),
    .dma_desc_fetch_rddata_i       (rddata),
    .dma_desc_fetch_readdatavalid_i(rdv),
    .dma_desc_fifo_wr_o            (fifo_wr),
    .dma_desc_fifo_wrdata_o        (wrdata),
    .dma_desc_fifo_full_i          (full),
    .dma_desc_fetch_busy_o         (busy),
    .dma_desc_fetch_chan_o         (chan)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Descriptor memory: word0 = own address, word4 = next pointer, word7[31] = owned.
  logic [31:0] mem [logic [31:0]];

  task automatic put_desc(input logic [31:0] a, input logic [31:0] nxt, input logic own);
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      w = a + 32'(i);
      if (i == 4) w = nxt;
      if (i == 7) w = {own, a[30:0] + 31'(i)};
      mem[a + 32'(4*i)] = w;
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  function automatic logic [DW-1:0] exp_desc(input logic [31:0] a);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = rd_mem(a + 32'(4*i));
    return r;
  endfunction

  function automatic logic [63:0] mk_ctrl(input logic r0, input logic p0, input logic r1, input logic p1);
    logic [63:0] c;
    c = '0;
    c[5] = r0; c[17] = p0; c[37] = r1; c[49] = p1;
    return c;
  endfunction

  // Responder modes, set by the main sequence.
  int hold_cycles = 0;
  bit gaps        = 1'b0;
  bit spurious    = 1'b0;
  int beats_total = 0;
  int stab_err    = 0;

  initial begin
    logic [31:0] a;
    waitreq = 1'b0;
    rdv     = 1'b0;
    rddata  = '0;
    forever begin
      @(posedge clk); #1;
      if (read_o === 1'b1) begin
        a = addr_o;
        if (hold_cycles > 0) begin
          waitreq = 1'b1;
          for (int k = 0; k < hold_cycles; k++) begin
            @(posedge clk); #1;
            if (read_o !== 1'b1 || addr_o !== a || bcount !== 4'd8) stab_err++;
          end
          waitreq = 1'b0;
        end
        @(posedge clk); #1;
        for (int b = 0; b < 8; b++) begin
          if (gaps && (b % 2 == 1)) begin
            @(posedge clk); #1;
          end
          rdv    = 1'b1;
          rddata = rd_mem(a + 32'(4*b));
          @(posedge clk); #1;
          rdv = 1'b0;
          beats_total++;
        end
        if (spurious) begin
          rdv    = 1'b1;
          rddata = 32'hDEAD_BEEF;
          @(posedge clk); #1;
          rdv = 1'b0;
        end
      end
    end
  end

  // Monitor: accepted bursts and FIFO writes.
  int          cyc = 0;
  int          last_rdv_cyc = 0;
  int          onehot_err = 0;
  logic [31:0] burst_addr_q [$];
  int          burst_ch_q [$];
  logic [DW-1:0] wr_data_q [$];
  int          wr_ch_q [$];
  int          lat_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdv === 1'b1) last_rdv_cyc <= cyc;
    if (fifo_wr !== '0) begin
      wr_data_q.push_back(wrdata);
      wr_ch_q.push_back(int'(chan));
      lat_q.push_back(cyc - last_rdv_cyc);
      if (fifo_wr !== (2'b01 << chan)) onehot_err <= onehot_err + 1;
    end
    if (read_o === 1'b1 && waitreq === 1'b0) begin
      burst_addr_q.push_back(addr_o);
      burst_ch_q.push_back(int'(chan));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input string tag, input logic [1:0] mask, input int maxc);
    int n;
    n = 0;
    tick(3);
    while (((busy & mask) != '0) && (n < maxc)) begin
      tick(1);
      n++;
    end
    check_eq({tag, "_done"}, DW'((busy & mask) == '0), DW'(1));
  endtask

  task automatic wait_burst(input string tag, input int base, input int maxc);
    int n;
    n = 0;
    while ((burst_addr_q.size() <= base) && (n < maxc)) begin
      tick(1);
      n++;
    end
    check_eq({tag, "_accepted"}, DW'(burst_addr_q.size() > base), DW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_b [8];
    int bb, wb, b0, herr, cnt;

    reset = 1'b1;
    full  = '0;
    ctrl  = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    fptr  = {32'h0, 32'h100};
    put_desc(32'h100, 32'h120, 1'b1);
    put_desc(32'h120, 32'h140, 1'b1);
    put_desc(32'h140, 32'h160, 1'b0);
    tick(3);

    // Reset values, with ch0 already requesting run.
    @(negedge clk);
    check_eq("rst_read",   DW'(read_o),  DW'(0));
    check_eq("rst_addr",   DW'(addr_o),  DW'(0));
    check_eq("rst_fifowr", DW'(fifo_wr), DW'(0));
    check_eq("rst_wrdata", wrdata,       DW'(0));
    check_eq("rst_chan",   DW'(chan),    DW'(0));
    check_eq("rst_busy",   DW'(busy),    DW'(0));
    check_eq("bcount",     DW'(bcount),  DW'(8));

    // Single-channel chain 0x100 -> 0x120 -> 0x140 (not owned).
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("t1_read_before_edge", DW'(read_o), DW'(0));
    @(negedge clk);
    check_eq("t1_read_latency", DW'(read_o), DW'(1));
    check_eq("t1_addr0",        DW'(addr_o), DW'(32'h100));
    wait_done("t1", 2'b01, 300);
    tick(20);
    @(negedge clk);
    check_eq("t1_read_idle",  DW'(read_o), DW'(0));
    check_eq("t1_busy",       DW'(busy[0]), DW'(0));
    check_eq("t1_bursts",     DW'(burst_addr_q.size()), DW'(3));
    check_eq("t1_burst2",     DW'(burst_addr_q[2]), DW'(32'h140));
    check_eq("t1_writes",     DW'(wr_data_q.size()), DW'(2));
    check_eq("t1_wr0_desc",   wr_data_q[0], exp_desc(32'h100));
    check_eq("t1_wr1_addr",   DW'(wr_data_q[1][31:0]), DW'(32'h120));
    check_eq("t1_wr_latency", DW'(lat_q[0]), DW'(2));

    // Two channels interleaving per descriptor.
    put_desc(32'h1000, 32'h1020, 1'b1);
    put_desc(32'h1020, 32'h1040, 1'b1);
    put_desc(32'h1040, 32'h1060, 1'b1);
    put_desc(32'h1060, 32'h1080, 1'b0);
    put_desc(32'h2000, 32'h2020, 1'b1);
    put_desc(32'h2020, 32'h2040, 1'b1);
    put_desc(32'h2040, 32'h2060, 1'b1);
    put_desc(32'h2060, 32'h2080, 1'b0);
    exp_b = '{32'h1000, 32'h2000, 32'h1020, 32'h2020, 32'h1040, 32'h2040, 32'h1060, 32'h2060};
    reset = 1'b1;
    ctrl  = mk_ctrl(1'b1, 1'b0, 1'b1, 1'b0);
    fptr  = {32'h2000, 32'h1000};
    tick(2);
    bb = burst_addr_q.size();
    wb = wr_data_q.size();
    reset = 1'b0;
    wait_done("t2", 2'b11, 600);
    tick(5);
    check_eq("t2_bursts", DW'(burst_addr_q.size() - bb), DW'(8));
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t2_burst%0d_addr", i), DW'(burst_addr_q[bb+i]), DW'(exp_b[i]));
      check_eq($sformatf("t2_burst%0d_chan", i), DW'(burst_ch_q[bb+i]), DW'(i % 2));
    end
    check_eq("t2_writes", DW'(wr_data_q.size() - wb), DW'(6));
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t2_wr%0d_addr", i), DW'(wr_data_q[wb+i][31:0]), DW'(exp_b[i]));
      check_eq($sformatf("t2_wr%0d_chan", i), DW'(wr_ch_q[wb+i]), DW'(i % 2));
    end
    check_eq("t2_onehot", DW'(onehot_err), DW'(0));

    // FIFO full at CHECK: hold in FIFO_WAIT, one write after full drops.
    ctrl = '0;
    tick(2);
    put_desc(32'h300, 32'h320, 1'b1);
    put_desc(32'h320, 32'h340, 1'b0);
    fptr = {32'h0, 32'h300};
    bb = burst_addr_q.size();
    wb = wr_data_q.size();
    b0 = beats_total;
    ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    wait_burst("t3", bb, 30);
    full[0] = 1'b1;
    cnt = 0;
    while ((beats_total < b0 + 8) && (cnt < 60)) begin
      @(negedge clk);
      cnt++;
    end
    herr = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (read_o !== 1'b0 || fifo_wr !== '0) herr++;
    end
    check_eq("t3_hold_quiet",    DW'(herr), DW'(0));
    check_eq("t3_no_write_full", DW'(wr_data_q.size() - wb), DW'(0));
    check_eq("t3_busy_in_wait",  DW'(busy[0]), DW'(1));
    full[0] = 1'b0;
    wait_done("t3", 2'b01, 200);
    tick(5);
    check_eq("t3_writes",   DW'(wr_data_q.size() - wb), DW'(1));
    check_eq("t3_wr_addr",  DW'(wr_data_q[wb][31:0]), DW'(32'h300));
    check_eq("t3_bursts",   DW'(burst_addr_q.size() - bb), DW'(2));
    check_eq("t3_burst1",   DW'(burst_addr_q[bb+1]), DW'(32'h320));

    // Park: chain restarts at the first pointer, nothing pushed.
    ctrl = '0;
    tick(2);
    put_desc(32'h200, 32'h220, 1'b0);
    fptr = {32'h0, 32'h200};
    bb = burst_addr_q.size();
    wb = wr_data_q.size();
    ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0);
    tick(60);
    @(negedge clk);
    check_eq("t4_busy", DW'(busy[0]), DW'(1));
    ctrl = '0;
    tick(20);
    check_eq("t4_bursts_ge4", DW'((burst_addr_q.size() - bb) >= 4), DW'(1));
    herr = 0;
    for (int i = bb; i < burst_addr_q.size(); i++)
      if (burst_addr_q[i] !== 32'h200) herr++;
    check_eq("t4_addr_all_200", DW'(herr), DW'(0));
    check_eq("t4_writes", DW'(wr_data_q.size() - wb), DW'(0));

    // Waitrequest, beat gaps and a trailing spurious valid.
    put_desc(32'h400, 32'h420, 1'b1);
    put_desc(32'h420, 32'h440, 1'b0);
    fptr = {32'h0, 32'h400};
    hold_cycles = 4;
    gaps        = 1'b1;
    spurious    = 1'b1;
    bb = burst_addr_q.size();
    wb = wr_data_q.size();
    ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done("t5", 2'b01, 300);
    tick(8);
    hold_cycles = 0;
    gaps        = 1'b0;
    spurious    = 1'b0;
    check_eq("t5_stable",  DW'(stab_err), DW'(0));
    check_eq("t5_writes",  DW'(wr_data_q.size() - wb), DW'(1));
    check_eq("t5_wr_desc", wr_data_q[wb], exp_desc(32'h400));
    check_eq("t5_bursts",  DW'(burst_addr_q.size() - bb), DW'(2));
    check_eq("t5_burst1",  DW'(burst_addr_q[bb+1]), DW'(32'h420));

    // Run dropped mid-burst: burst completes, descriptor discarded.
    ctrl = '0;
    tick(2);
    put_desc(32'h500, 32'h520, 1'b1);
    fptr = {32'h0, 32'h500};
    gaps = 1'b1;
    bb = burst_addr_q.size();
    wb = wr_data_q.size();
    ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    wait_burst("t6a", bb, 30);
    tick(2);
    ctrl = '0;
    tick(30);
    @(negedge clk);
    check_eq("t6a_writes", DW'(wr_data_q.size() - wb), DW'(0));
    check_eq("t6a_read",   DW'(read_o), DW'(0));
    check_eq("t6a_bursts", DW'(burst_addr_q.size() - bb), DW'(1));
    check_eq("t6a_busy",   DW'(busy[0]), DW'(0));

    // Asynchronous reset in the middle of WAIT_DATA.
    bb = burst_addr_q.size();
    ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    wait_burst("t6b", bb, 30);
    tick(2);
    #3;
    reset = 1'b1;
    ctrl  = '0;
    #1;
    check_eq("t6b_rst_read",   DW'(read_o),  DW'(0));
    check_eq("t6b_rst_addr",   DW'(addr_o),  DW'(0));
    check_eq("t6b_rst_wrdata", wrdata,       DW'(0));
    check_eq("t6b_rst_busy",   DW'(busy),    DW'(0));
    check_eq("t6b_rst_fifowr", DW'(fifo_wr), DW'(0));
    tick(3);
    reset = 1'b0;
    tick(25);
    @(negedge clk);
    check_eq("t6b_writes", DW'(wr_data_q.size() - wb), DW'(0));
    check_eq("t6b_read",   DW'(read_o), DW'(0));
    check_eq("t6b_bursts", DW'(burst_addr_q.size() - bb), DW'(1));
    check_eq("t6b_chan",   DW'(chan), DW'(0));
    gaps = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
